// File: rtl/mem_wb_reg_pkg.sv
// Shared pipeline definitions: default field widths and write-back control bit positions,
// common to all inter-stage registers.
package mem_wb_reg_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_REG_W  = 5;
  localparam int unsigned DEF_WB_W   = 2;

  // Bit positions inside the WB control bundle; stage registers carry them untouched.
  localparam int unsigned REGWRITE_BIT = 1;
  localparam int unsigned MEMTOREG_BIT = 0;

endpackage

// File: rtl/mem_wb_reg_pipe_reg.sv
// Generic pipeline field register: parameterised-width D flop with asynchronous
// active-low clear to zero.
module pipe_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: captures write-back control, memory read data, ALU result and
// destination index on every rising edge; outputs come straight from flops.
module mem_wb_reg
  import mem_wb_reg_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned REG_W  = DEF_REG_W,
  parameter int unsigned WB_W   = DEF_WB_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WB_W-1:0]   WB,
  input  logic [DATA_W-1:0] memory_Output,
  input  logic [DATA_W-1:0] ALU_Output,
  input  logic [REG_W-1:0]  Rd,
  output logic [WB_W-1:0]   WB_WB,
  output logic [DATA_W-1:0] WB_memory_Output,
  output logic [DATA_W-1:0] WB_ALU_Output,
  output logic [REG_W-1:0]  WB_Rd
);

  pipe_reg #(
    .WIDTH (WB_W)
  ) u_wb_reg (
    .clk (clk),
    .rst (rst),
    .d   (WB),
    .q   (WB_WB)
  );

  pipe_reg #(
    .WIDTH (DATA_W)
  ) u_mem_reg (
    .clk (clk),
    .rst (rst),
    .d   (memory_Output),
    .q   (WB_memory_Output)
  );

  pipe_reg #(
    .WIDTH (DATA_W)
  ) u_alu_reg (
    .clk (clk),
    .rst (rst),
    .d   (ALU_Output),
    .q   (WB_ALU_Output)
  );

  pipe_reg #(
    .WIDTH (REG_W)
  ) u_rd_reg (
    .clk (clk),
    .rst (rst),
    .d   (Rd),
    .q   (WB_Rd)
  );

endmodule

// File: tb/tb_mem_wb_reg.sv
// Self-checking bench for mem_wb_reg: expected outputs are queued when inputs are driven
// and compared one edge later.
module tb_mem_wb_reg;
  import mem_wb_reg_pkg::*;

  typedef struct packed {
    logic [DEF_WB_W-1:0]   wb;
    logic [DEF_DATA_W-1:0] mem;
    logic [DEF_DATA_W-1:0] alu;
    logic [DEF_REG_W-1:0]  rd;
  } fields_t;

  logic                  clk;
  logic                  rst;
  logic [DEF_WB_W-1:0]   WB;
  logic [DEF_DATA_W-1:0] memory_Output;
  logic [DEF_DATA_W-1:0] ALU_Output;
  logic [DEF_REG_W-1:0]  Rd;
  logic [DEF_WB_W-1:0]   WB_WB;
  logic [DEF_DATA_W-1:0] WB_memory_Output;
  logic [DEF_DATA_W-1:0] WB_ALU_Output;
  logic [DEF_REG_W-1:0]  WB_Rd;

  fields_t sb_q[$];
  fields_t exp_v;
  fields_t obs_v;
  int      n_checks = 0;
  int      n_fail   = 0;

  mem_wb_reg #(
    .DATA_W (DEF_DATA_W),
    .REG_W  (DEF_REG_W),
    .WB_W   (DEF_WB_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .WB               (WB),
    .memory_Output    (memory_Output),
    .ALU_Output       (ALU_Output),
    .Rd               (Rd),
    .WB_WB            (WB_WB),
    .WB_memory_Output (WB_memory_Output),
    .WB_ALU_Output    (WB_ALU_Output),
    .WB_Rd            (WB_Rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic fields_t observe();
    return {WB_WB, WB_memory_Output, WB_ALU_Output, WB_Rd};
  endfunction

  // Drives the inputs and records what the register must show after the next edge.
  task automatic apply(input fields_t v);
    WB            = v.wb;
    memory_Output = v.mem;
    ALU_Output    = v.alu;
    Rd            = v.rd;
    if (rst) sb_q.push_back(v);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    apply('{wb: 2'b01, mem: 32'd1, alu: 32'd0, rd: 5'd1});
    #1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      obs_v = observe();
      n_checks++;
      if (obs_v !== '0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %h, want 0", i, obs_v);
      end
    end
  endtask

  task automatic test_release();
    @(negedge clk);
    rst = 1'b1;
    apply('{wb: 2'b01, mem: 32'd1, alu: 32'd0, rd: 5'd1});
    #1;
    obs_v = observe();
    n_checks++;
    if (obs_v !== '0) begin
      n_fail++;
      $display("FAIL release_pre_edge: got %h, want 0", obs_v);
    end
    @(posedge clk);
    #1;
    obs_v = observe();
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL release_edge: scoreboard empty, got %h", obs_v);
    end else begin
      exp_v = sb_q.pop_front();
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL release_edge: got %h, want %h", obs_v, exp_v);
      end
    end
  endtask

  task automatic test_pipelining();
    fields_t prev;
    fields_t v;
    prev = observe();
    v = '{wb: '0, mem: 32'd1, alu: 32'hDEADBEEF, rd: 5'd31};
    v.wb[REGWRITE_BIT] = 1'b1;
    v.wb[MEMTOREG_BIT] = 1'b0;
    apply(v);
    #3;
    obs_v = observe();
    n_checks++;
    if (obs_v !== '{wb: 2'b01, mem: 32'd1, alu: 32'd0, rd: 5'd1}) begin
      n_fail++;
      $display("FAIL pipe_hold: got %h, want %h", obs_v, prev);
    end
    @(posedge clk);
    #1;
    obs_v = observe();
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL pipe_edge: scoreboard empty, got %h", obs_v);
    end else begin
      exp_v = sb_q.pop_front();
      if (obs_v !== exp_v || obs_v.wb !== 2'b10) begin
        n_fail++;
        $display("FAIL pipe_edge: got %h, want %h", obs_v, exp_v);
      end
    end
  endtask

  task automatic test_async_clear();
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    obs_v = observe();
    n_checks++;
    if (obs_v !== '0) begin
      n_fail++;
      $display("FAIL async_clear: got %h, want 0", obs_v);
    end
    apply('{wb: 2'b11, mem: 32'h1234_5678, alu: 32'h9ABC_DEF0, rd: 5'd7});
    @(posedge clk);
    #1;
    obs_v = observe();
    n_checks++;
    if (obs_v !== '0) begin
      n_fail++;
      $display("FAIL edge_in_reset: got %h, want 0", obs_v);
    end
    @(negedge clk);
    rst = 1'b1;
    apply('{wb: 2'b11, mem: 32'h1234_5678, alu: 32'h9ABC_DEF0, rd: 5'd7});
    @(posedge clk);
    #1;
    obs_v = observe();
    n_checks++;
    if (sb_q.size() != 1) begin
      n_fail++;
      $display("FAIL rerelease: scoreboard depth %0d, want 1", sb_q.size());
    end else begin
      exp_v = sb_q.pop_front();
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL rerelease: got %h, want %h", obs_v, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      apply('{wb: 2'b00, mem: i, alu: 32'h100 + i, rd: i[4:0]});
      @(posedge clk);
      #1;
      obs_v = observe();
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL b2b[%0d]: scoreboard empty, got %h", i, obs_v);
      end else begin
        exp_v = sb_q.pop_front();
        if (obs_v !== exp_v || WB_memory_Output !== i) begin
          n_fail++;
          $display("FAIL b2b[%0d]: got mem=%0d all=%h, want mem=%0d all=%h",
                   i, WB_memory_Output, obs_v, i, exp_v);
        end
      end
    end
  endtask

  task automatic test_full_width();
    for (int i = 0; i < 2; i++) begin
      apply((i == 0) ? '1 : '0);
      @(posedge clk);
      #1;
      obs_v = observe();
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL full_width[%0d]: scoreboard empty, got %h", i, obs_v);
      end else begin
        exp_v = sb_q.pop_front();
        if (obs_v !== exp_v) begin
          n_fail++;
          $display("FAIL full_width[%0d]: got %h, want %h", i, obs_v, exp_v);
        end
      end
    end
  endtask

  initial begin
    rst           = 1'b0;
    WB            = '0;
    memory_Output = '0;
    ALU_Output    = '0;
    Rd            = '0;
    test_reset();
    test_release();
    test_pipelining();
    test_async_clear();
    test_back_to_back();
    test_full_width();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
